// File: rtl/neuron_pkg.sv
// Shared constants, FSM state type and fixed-point helpers for the layer sequencer.
package neuron_pkg;

  localparam int NEURONS = 10;
  localparam int LANES   = 16;
  localparam int BATCHES = 49;
  localparam int PIX_W   = 10;
  localparam int WGT_W   = 19;
  localparam int OUT_W   = 26;
  localparam int ACC_W   = 40;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    FINAL,
    DONE
  } state_e;

  // Clamp a Q.18 accumulator value into the signed Q8.18 output range.
  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if (v[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){v[ACC_W-1]}}) begin
      return v[OUT_W-1:0];
    end else if (v[ACC_W-1]) begin
      return {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      return {1'b0, {(OUT_W-1){1'b1}}};
    end
  endfunction

  function automatic logic signed [ACC_W-1:0] extend_bias(input logic signed [WGT_W-1:0] b);
    return {{(ACC_W-WGT_W){b[WGT_W-1]}}, b};
  endfunction

endpackage

// File: rtl/neuron_layer_sequencer_if.sv
// Fetch bus between the layer sequencer (master) and the weight/pixel store (slave).
interface neuron_layer_sequencer_if
  import neuron_pkg::*;
#(
  parameter int NUM_NEURONS  = NEURONS,
  parameter int NUM_LANES    = LANES,
  parameter int NUM_BATCHES  = BATCHES,
  parameter int PIXEL_WIDTH  = PIX_W,
  parameter int WEIGHT_WIDTH = WGT_W
);

  logic                              rd_en;
  logic [$clog2(NUM_NEURONS)-1:0]    rd_neuron;
  logic [$clog2(NUM_BATCHES)-1:0]    rd_batch;
  logic                              rd_valid;
  logic [NUM_LANES*PIXEL_WIDTH-1:0]  lane_pixels;
  logic [NUM_LANES*WEIGHT_WIDTH-1:0] lane_weights;
  logic [WEIGHT_WIDTH-1:0]           bias;

  modport master (
    output rd_en, rd_neuron, rd_batch,
    input  rd_valid, lane_pixels, lane_weights, bias
  );

  modport slave (
    input  rd_en, rd_neuron, rd_batch,
    output rd_valid, lane_pixels, lane_weights, bias
  );

endinterface

// File: rtl/mac_lane_adder.sv
// Multiplies every pixel/weight lane of one batch and registers the signed lane sum.
module mac_lane_adder
  import neuron_pkg::*;
#(
  parameter int NUM_LANES    = LANES,
  parameter int PIXEL_WIDTH  = PIX_W,
  parameter int WEIGHT_WIDTH = WGT_W,
  parameter int ACC_WIDTH    = ACC_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [NUM_LANES*PIXEL_WIDTH-1:0]  lane_pixels,
  input  logic [NUM_LANES*WEIGHT_WIDTH-1:0] lane_weights,
  output logic signed [ACC_WIDTH-1:0]       lane_sum_q
);

  localparam int PW = PIXEL_WIDTH + WEIGHT_WIDTH + 1;

  logic signed [PW-1:0]        pix_ext;
  logic signed [PW-1:0]        wgt_ext;
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] lane_sum_d;

  // Pixels are unsigned, so they get a zero top bit before the signed multiply.
  always_comb begin
    lane_sum_d = '0;
    pix_ext    = '0;
    wgt_ext    = '0;
    prod       = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      pix_ext    = {{(PW-PIXEL_WIDTH){1'b0}}, lane_pixels[i*PIXEL_WIDTH +: PIXEL_WIDTH]};
      wgt_ext    = {{(PW-WEIGHT_WIDTH){lane_weights[i*WEIGHT_WIDTH+WEIGHT_WIDTH-1]}},
                    lane_weights[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]};
      prod       = pix_ext * wgt_ext;
      lane_sum_d = lane_sum_d + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_sum_q <= '0;
    end else if (load) begin
      lane_sum_q <= lane_sum_d;
    end
  end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Walks every neuron through all input batches, emits saturated results and the argmax class.
// Optional RELU_EN macro clamps negative results to zero before output and argmax.
module neuron_layer_sequencer
  import neuron_pkg::*;
#(
  parameter int NUM_NEURONS  = NEURONS,
  parameter int NUM_LANES    = LANES,
  parameter int NUM_BATCHES  = BATCHES,
  parameter int PIXEL_WIDTH  = PIX_W,
  parameter int WEIGHT_WIDTH = WGT_W,
  parameter int OUTPUT_WIDTH = OUT_W,
  parameter int ACC_WIDTH    = ACC_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  output logic                           busy,
  neuron_layer_sequencer_if.master       store,
  output logic                           out_valid,
  output logic [$clog2(NUM_NEURONS)-1:0] out_neuron,
  output logic [OUTPUT_WIDTH-1:0]        out_data,
  output logic                           done,
  output logic [$clog2(NUM_NEURONS)-1:0] class_idx
);

  localparam int NW = $clog2(NUM_NEURONS);
  localparam int BW = $clog2(NUM_BATCHES);
  localparam logic [NW-1:0] LAST_NEURON = NW'(NUM_NEURONS - 1);
  localparam logic [BW-1:0] LAST_BATCH  = BW'(NUM_BATCHES - 1);

  state_e state_q, state_d;
  logic [NW-1:0] neuron_q, neuron_d;
  logic [BW-1:0] batch_q, batch_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic add_pend_q, add_pend_d;
  logic busy_q, busy_d, rd_en_q, rd_en_d, out_valid_q, out_valid_d, done_q, done_d;
  logic [NW-1:0] out_neuron_q, out_neuron_d, max_idx_q, max_idx_d, class_idx_q, class_idx_d;
  logic [OUTPUT_WIDTH-1:0] out_data_q, out_data_d;
  logic signed [OUTPUT_WIDTH-1:0] max_val_q, max_val_d, result;
  logic signed [ACC_WIDTH-1:0] lane_sum, biased;
  logic lane_load;

  assign lane_load = store.rd_valid && (state_q == WAIT);

  mac_lane_adder #(
    .NUM_LANES   (NUM_LANES),
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .WEIGHT_WIDTH(WEIGHT_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH)
  ) u_mac (
    .clk         (clk),
    .rst         (rst),
    .load        (lane_load),
    .lane_pixels (store.lane_pixels),
    .lane_weights(store.lane_weights),
    .lane_sum_q  (lane_sum)
  );

  always_comb begin
    biased = acc_q + extend_bias(store.bias);
    result = saturate(biased);
`ifdef RELU_EN
    if (result[OUTPUT_WIDTH-1]) begin
      result = '0;
    end
`endif
  end

  // The lane sum registered in one cycle is folded into the accumulator in the next.
  always_comb begin
    state_d      = state_q;
    neuron_d     = neuron_q;
    batch_d      = batch_q;
    acc_d        = add_pend_q ? acc_q + lane_sum : acc_q;
    add_pend_d   = lane_load;
    busy_d       = busy_q;
    rd_en_d      = 1'b0;
    out_valid_d  = 1'b0;
    done_d       = 1'b0;
    out_neuron_d = out_neuron_q;
    out_data_d   = out_data_q;
    max_val_d    = max_val_q;
    max_idx_d    = max_idx_q;
    class_idx_d  = class_idx_q;
    case (state_q)
      IDLE: begin
        busy_d = start;
        if (start) begin
          neuron_d  = '0;
          batch_d   = '0;
          acc_d     = '0;
          max_val_d = '0;
          max_idx_d = '0;
          rd_en_d   = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (store.rd_valid) begin
          if (batch_q < LAST_BATCH) begin
            batch_d = batch_q + BW'(1);
            rd_en_d = 1'b1;
            state_d = REQ;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: state_d = FINAL;
      FINAL: begin
        out_data_d   = result;
        out_valid_d  = 1'b1;
        out_neuron_d = neuron_q;
        // Neuron 0 seeds the running max; strict compare keeps ties on the lower index.
        if ((neuron_q == '0) || (result > max_val_q)) begin
          max_val_d = result;
          max_idx_d = neuron_q;
        end
        if (neuron_q < LAST_NEURON) begin
          neuron_d = neuron_q + NW'(1);
          batch_d  = '0;
          acc_d    = '0;
          rd_en_d  = 1'b1;
          state_d  = REQ;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_d      = 1'b1;
        class_idx_d = max_idx_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      neuron_q     <= '0;
      batch_q      <= '0;
      acc_q        <= '0;
      add_pend_q   <= 1'b0;
      busy_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      out_neuron_q <= '0;
      out_data_q   <= '0;
      max_val_q    <= '0;
      max_idx_q    <= '0;
      class_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      neuron_q     <= neuron_d;
      batch_q      <= batch_d;
      acc_q        <= acc_d;
      add_pend_q   <= add_pend_d;
      busy_q       <= busy_d;
      rd_en_q      <= rd_en_d;
      out_valid_q  <= out_valid_d;
      done_q       <= done_d;
      out_neuron_q <= out_neuron_d;
      out_data_q   <= out_data_d;
      max_val_q    <= max_val_d;
      max_idx_q    <= max_idx_d;
      class_idx_q  <= class_idx_d;
    end
  end

  assign busy            = busy_q;
  assign store.rd_en     = rd_en_q;
  assign store.rd_neuron = neuron_q;
  assign store.rd_batch  = batch_q;
  assign out_valid       = out_valid_q;
  assign out_neuron      = out_neuron_q;
  assign out_data        = out_data_q;
  assign done            = done_q;
  assign class_idx       = class_idx_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Self-checking bench: behavioural store model feeding the sequencer, scoreboard of neuron results.
module tb_neuron_layer_sequencer;
  import neuron_pkg::*;

  localparam int NW = $clog2(NEURONS);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, out_valid, done;
  logic [NW-1:0] out_neuron, class_idx;
  logic [OUT_W-1:0] out_data;

  neuron_layer_sequencer_if bus ();

  neuron_layer_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .store     (bus),
    .out_valid (out_valid),
    .out_neuron(out_neuron),
    .out_data  (out_data),
    .done      (done),
    .class_idx (class_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [OUT_W-1:0] d;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int checks = 0;
  int passes = 0;
  int mode = 0;
  bit rand_lat = 1'b0;
  int rd_count = 0;
  int first_rd = -1;
  int done_cycle = 0;
  int cycle_cnt = 0;
  bit done_seen = 1'b0;
  bit pass_over = 1'b0;
  int exp_class = 0;

  function automatic logic [PIX_W-1:0] pix_of(int n, int b, int l);
    case (mode)
      2:       return 10'd1023;
      4:       return PIX_W'((n * 37 + b * 11 + l * 5) % 1024);
      default: return 10'd1;
    endcase
  endfunction

  function automatic logic signed [WGT_W-1:0] wgt_of(int n, int b, int l);
    case (mode)
      0, 1:    return 19'h00100;
      2:       return 19'h3FFFF;
      3:       return 19'h40000;
      4:       return WGT_W'(((n * 29 + b * 13 + l * 7) % 129) - 64);
      default: return '0;
    endcase
  endfunction

  function automatic logic signed [WGT_W-1:0] bias_of(int n);
    case (mode)
      1:       return WGT_W'(n * 256);
      4:       return WGT_W'(n * 4660 - 32768);
      default: return '0;
    endcase
  endfunction

  // Reference neuron value in wide integer arithmetic, Q.18 throughout.
  function automatic longint model(int n);
    longint s = 0;
    for (int b = 0; b < BATCHES; b++) begin
      for (int l = 0; l < LANES; l++) begin
        s += longint'(pix_of(n, b, l)) * longint'(wgt_of(n, b, l));
      end
    end
    s += longint'(bias_of(n));
    if (s > 64'sd33554431) s = 64'sd33554431;
    else if (s < -64'sd33554432) s = -64'sd33554432;
`ifdef RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic load_expected();
    longint v;
    longint best;
    exp_q.delete();
    best = 0;
    for (int n = 0; n < NEURONS; n++) begin
      v = model(n);
      exp_q.push_back('{n, v[OUT_W-1:0]});
      if (n == 0 || v > best) begin
        best = v;
        exp_class = n;
      end
    end
  endtask

  task automatic scramble();
    for (int l = 0; l < LANES; l++) begin
      bus.lane_pixels[l*PIX_W +: PIX_W]  = PIX_W'($urandom);
      bus.lane_weights[l*WGT_W +: WGT_W] = WGT_W'($urandom);
    end
  endtask

  task automatic fill(int n, int b);
    for (int l = 0; l < LANES; l++) begin
      bus.lane_pixels[l*PIX_W +: PIX_W]  = pix_of(n, b, l);
      bus.lane_weights[l*WGT_W +: WGT_W] = wgt_of(n, b, l);
    end
  endtask

  // Store model: one response per request, latency 1 or random 1..5, stray valid in REQ when random.
  initial begin : store_model
    int rn, rb, lat;
    bus.rd_valid     = 1'b0;
    bus.lane_pixels  = '0;
    bus.lane_weights = '0;
    @(posedge clk);
    #1;
    forever begin
      if (bus.rd_en === 1'b1) begin
        rn  = int'(bus.rd_neuron);
        rb  = int'(bus.rd_batch);
        lat = rand_lat ? int'($urandom_range(1, 5)) : 1;
        if (rand_lat && $urandom_range(0, 2) == 0) begin
          scramble();
          bus.rd_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.rd_valid = 1'b0;
        repeat (lat - 1) begin
          @(posedge clk);
          #1;
        end
        fill(rn, rb);
        bus.rd_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rd_valid = 1'b0;
        if (rand_lat) scramble();
      end else begin
        @(posedge clk);
        #1;
      end
    end
  end

  initial begin : bias_model
    bus.bias = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.bias = bias_of(int'(bus.rd_neuron));
    end
  end

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Scoreboard and event monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("[TB] FAIL result_extra: got neuron %0d data %h, required no result", out_neuron, out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_neuron !== NW'(e.n) || out_data !== e.d)
          $display("[TB] FAIL result: got neuron %0d data %h, required neuron %0d data %h",
                   out_neuron, out_data, e.n, e.d);
        else passes++;
      end
    end
    if (bus.rd_en === 1'b1) begin
      rd_count++;
      if (first_rd < 0) first_rd = cycle_cnt;
    end
    if (done === 1'b1) begin
      done_seen  = 1'b1;
      done_cycle = cycle_cnt;
    end
  end

  task automatic run_pass(input int m, input bit rl);
    mode = m;
    rand_lat = rl;
    load_expected();
    rd_count = 0;
    first_rd = -1;
    done_seen = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1 || bus.rd_en !== 1'b1)
      $display("[TB] FAIL start_accept: got busy %b rd_en %b, required 1 1", busy, bus.rd_en);
    else passes++;
    for (int i = 0; i < 8000 && !done_seen; i++) @(posedge clk);
    #1;
    checks++;
    if (!done_seen) $display("[TB] FAIL done_timeout: got no done, required done within 8000 cycles");
    else passes++;
    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL results_missing: got %0d pending, required 0", exp_q.size());
    else passes++;
    checks++;
    if (class_idx !== NW'(exp_class))
      $display("[TB] FAIL class_idx: got %0d, required %0d", class_idx, exp_class);
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL busy_after_done: got %b, required 0", busy);
    else passes++;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, bus.rd_en, out_valid, done} !== 4'b0)
      $display("[TB] FAIL reset_ctrl: got %b, required 0000", {busy, bus.rd_en, out_valid, done});
    else passes++;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.rd_neuron, bus.rd_batch, out_neuron, out_data, class_idx} !== '0)
      $display("[TB] FAIL reset_data: got neuron %0d batch %0d out %0d/%h class %0d, required all 0",
               bus.rd_neuron, bus.rd_batch, out_neuron, out_data, class_idx);
    else passes++;
    rst = 1'b1;
  endtask

  task automatic test_basic();
    run_pass(0, 1'b0);
    checks++;
    if (done_cycle - first_rd != 1001)
      $display("[TB] FAIL done_latency: got %0d, required 1001", done_cycle - first_rd);
    else passes++;
    checks++;
    if (rd_count != 490) $display("[TB] FAIL rd_count_basic: got %0d, required 490", rd_count);
    else passes++;
  endtask

  task automatic test_bias();
    run_pass(1, 1'b0);
  endtask

  task automatic test_saturate();
    run_pass(2, 1'b0);
    run_pass(3, 1'b0);
  endtask

  task automatic test_mixed();
    run_pass(4, 1'b0);
  endtask

  task automatic test_random_latency();
    pass_over = 1'b0;
    fork
      begin
        run_pass(4, 1'b1);
        pass_over = 1'b1;
      end
      begin
        while (!pass_over) begin
          @(posedge clk);
          #2;
          if (busy === 1'b1 && done !== 1'b1) start = ($urandom_range(0, 5) == 0);
          else if (busy === 1'b1) start = 1'b0;
        end
      end
    join
    start = 1'b0;
    rand_lat = 1'b0;
    checks++;
    if (rd_count != 490) $display("[TB] FAIL rd_count_random: got %0d, required 490", rd_count);
    else passes++;
  endtask

  task automatic test_reset_mid_pass();
    bit found = 1'b0;
    mode = 0;
    load_expected();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (bus.rd_en === 1'b1 && bus.rd_neuron == 4 && bus.rd_batch == 20) found = 1'b1;
    end
    checks++;
    if (!found) $display("[TB] FAIL reach_n4_b20: got no such request, required one");
    else passes++;
    rst = 1'b0;
    #1;
    checks++;
    if ({busy, bus.rd_en, out_valid, done, bus.rd_neuron, bus.rd_batch, out_neuron, out_data, class_idx} !== '0)
      $display("[TB] FAIL mid_reset_outputs: got busy %b rd_en %b neuron %0d batch %0d out %0d/%h class %0d, required all 0",
               busy, bus.rd_en, bus.rd_neuron, bus.rd_batch, out_neuron, out_data, class_idx);
    else passes++;
    repeat (8) @(posedge clk);
    exp_q.delete();
    #1 rst = 1'b1;
    run_pass(1, 1'b0);
    checks++;
    if (rd_count != 490) $display("[TB] FAIL rd_count_after_reset: got %0d, required 490", rd_count);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bias();
    test_saturate();
    test_mixed();
    test_random_latency();
    test_reset_mid_pass();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
